// File: rtl/img_readout_packer.sv
// img_readout_packer
// Accepts pixel words from the SDRAM readout stream, optionally keeps only the
// even-indexed pixels, and splits each kept pixel into OUT_W-bit beats held in
// a beat FIFO. The SPI side pulls beats one at a time and is told through
// chunk_ready when a full chunk, or the final short chunk, can be pulled
// without underrunning.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; no pixels accepted
// S_RUN    | accepting pixels until cfg_pixelCount have been consumed
// S_DRAIN  | all pixels consumed; waiting for the FIFO to empty
// S_DONE   | one-cycle completion pulse, then back to S_IDLE

module img_readout_packer #(
    parameter int PIXEL_W     = 16,
    parameter int OUT_W       = 8,
    parameter int DEPTH       = 64,
    parameter int CHUNK_BEATS = 32,
    parameter int COUNT_W     = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] cfg_pixelCount,
    input  logic               cfg_skip,
    input  logic               in_valid,
    input  logic [PIXEL_W-1:0] in_data,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    output logic               chunk_ready,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam int R  = PIXEL_W / OUT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = COUNT_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [COUNT_W-1:0] pix_count;
    logic               skip_odd;
    logic [COUNT_W-1:0] pix_idx;

    logic [OUT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;
    logic [BW-1:0]      beats_left;
    logic               chunk_ready_q;
    logic               underrun_q;

    logic               start_ok;
    logic               accept;
    logic               wr_en;
    logic               pop;
    logic               last_pix;
    logic [COUNT_W-1:0] kept_pix;
    logic [BW-1:0]      kept_beats;

    // Handshake decode and start-time beat accounting.
    always_comb begin
        start_ok   = start && (state == S_IDLE);
        in_ready   = (state == S_RUN) && (occ <= CW'(DEPTH - R));
        accept     = in_valid && in_ready;
        // odd-indexed pixels are consumed but never written when decimating
        wr_en      = accept && !(skip_odd && pix_idx[0]);
        pop        = out_ready && (occ != '0);
        last_pix   = (pix_idx == (pix_count - COUNT_W'(1)));
        kept_pix   = cfg_skip ? ((cfg_pixelCount >> 1) + COUNT_W'(cfg_pixelCount[0]))
                              : cfg_pixelCount;
        kept_beats = BW'(kept_pix) * BW'(R);
    end

    // Output decode; out_data is forced to zero while the FIFO is empty so
    // stale storage never leaks onto the SPI mux.
    always_comb begin
        out_valid   = (occ != '0);
        out_data    = out_valid ? mem[rd_ptr] : '0;
        chunk_ready = chunk_ready_q;
        underrun    = underrun_q;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
    end

    // Sequencing FSM: config latch, pixel index and state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pix_count <= '0;
            skip_odd  <= 1'b0;
            pix_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pix_count <= cfg_pixelCount;
                        skip_odd  <= cfg_skip;
                        pix_idx   <= '0;
                        state     <= (cfg_pixelCount == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pix_idx <= pix_idx + COUNT_W'(1);
                        if (last_pix) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (occ == '0) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Beat storage: a kept pixel is written as R consecutive beats, LS slice first.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < R; k++) begin
                mem[wr_ptr + AW'(k)] <= in_data[k*OUT_W +: OUT_W];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(R);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + (wr_en ? CW'(R) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        end
    end

    // Beats still owed to the consumer for the current transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left <= '0;
        end else if (start_ok) begin
            beats_left <= kept_beats;
        end else if (pop && (beats_left != '0)) begin
            beats_left <= beats_left - BW'(1);
        end
    end

    // Chunk availability, registered from the current occupancy: either a full
    // chunk is buffered or everything that is still owed is buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_ready_q <= 1'b0;
        end else begin
            chunk_ready_q <= (occ >= CW'(CHUNK_BEATS)) ||
                             ((BW'(occ) == beats_left) && (beats_left != '0));
        end
    end

    // Sticky underrun flag; a pull on an empty FIFO wins over a same-cycle start.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (out_ready && (occ == '0)) begin
            underrun_q <= 1'b1;
        end else if (start_ok) begin
            underrun_q <= 1'b0;
        end
    end

endmodule
